// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the instruction/data memory arbiter
package mem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      INST = 1'b0,
      DATA = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select: load/store first, fetch after a data streak
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4
) (
   input  logic             inst_req,
   input  logic             data_req,
   input  logic [CNT_W-1:0] streak,
   output logic             grant_inst,
   output logic             grant_data
);

   localparam logic [CNT_W-1:0] STREAK_LIMIT = CNT_W'(MAX_STREAK);

   // Data yields to a waiting fetch only once it has used up its streak.
   assign grant_data = data_req && (!inst_req || (streak < STREAK_LIMIT));
   assign grant_inst = inst_req && !grant_data;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes fetch and load/store traffic onto one fixed-latency memory port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_LAST     = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] STREAK_LIMIT = CNT_W'(MAX_STREAK);

   state_t           state;
   owner_t           owner;
   logic [CNT_W-1:0] streak;
   logic [CNT_W-1:0] lat_cnt;
   logic             pick_inst;
   logic             pick_data;

   mem_arb_pick #(
      .MAX_STREAK (MAX_STREAK)
   ) u_pick (
      .inst_req   (inst_req),
      .data_req   (data_req),
      .streak     (streak),
      .grant_inst (pick_inst),
      .grant_data (pick_data)
   );

   // Grants are Mealy; gating with reset keeps them quiet while reset is held.
   assign inst_gnt = reset && (state == IDLE) && pick_inst;
   assign data_gnt = reset && (state == IDLE) && pick_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= INST;
         streak      <= '0;
         lat_cnt     <= '0;
         mem_en      <= 1'b0;
         mem_rw      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         inst_rvalid <= 1'b0;
         inst_rdata  <= '0;
         data_rvalid <= 1'b0;
         data_rdata  <= '0;
      end else begin
         mem_en      <= 1'b0;
         inst_rvalid <= 1'b0;
         data_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (data_gnt) begin
                  owner     <= DATA;
                  mem_addr  <= data_addr;
                  mem_rw    <= data_we;
                  mem_wdata <= data_wdata;
                  mem_en    <= 1'b1;
                  state     <= ACCESS;
                  if (!inst_req) begin
                     streak <= '0;
                  end else if (streak < STREAK_LIMIT) begin
                     streak <= streak + 1'b1;
                  end
               end else if (inst_gnt) begin
                  owner     <= INST;
                  mem_addr  <= inst_addr;
                  mem_rw    <= 1'b0;
                  mem_wdata <= '0;
                  mem_en    <= 1'b1;
                  streak    <= '0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               lat_cnt <= CNT_W'(1);
               state   <= WAIT;
            end
            WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  // Stores acknowledge with zero data rather than whatever the bus carries.
                  if (owner == DATA) begin
                     data_rdata  <= mem_rw ? '0 : mem_rdata;
                     data_rvalid <= 1'b1;
                  end else begin
                     inst_rdata  <= mem_rdata;
                     inst_rvalid <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter at latency 1 and 3
module tb_mem_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        inst_req, inst_gnt, inst_rvalid;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_we, data_gnt, data_rvalid;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_en, mem_rw;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        s_inst_req, s_inst_gnt, s_inst_rvalid;
   logic [31:0] s_inst_addr, s_inst_rdata;
   logic        s_data_req, s_data_we, s_data_gnt, s_data_rvalid;
   logic [31:0] s_data_addr, s_data_wdata, s_data_rdata;
   logic        s_mem_en, s_mem_rw;
   logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .MAX_STREAK(4)) dut (
      .clock(clock), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
      .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata), .mem_en(mem_en), .mem_rw(mem_rw),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .MAX_STREAK(4)) dut_slow (
      .clock(clock), .reset(reset),
      .inst_req(s_inst_req), .inst_addr(s_inst_addr), .inst_gnt(s_inst_gnt),
      .inst_rvalid(s_inst_rvalid), .inst_rdata(s_inst_rdata),
      .data_req(s_data_req), .data_we(s_data_we), .data_addr(s_data_addr),
      .data_wdata(s_data_wdata), .data_gnt(s_data_gnt), .data_rvalid(s_data_rvalid),
      .data_rdata(s_data_rdata), .mem_en(s_mem_en), .mem_rw(s_mem_rw),
      .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   // Memory returns the word only in the exact cycle LATENCY after mem_en; garbage otherwise.
   logic [32:0]      p1 = '0;
   logic [2:0][32:0] p3 = '0;
   always @(posedge clock) begin
      p1 <= {mem_en, mem_addr};
      p3 <= {p3[1:0], {s_mem_en, s_mem_addr}};
   end
   assign mem_rdata   = p1[32]    ? mem_word(p1[31:0])    : 32'hBAD0_BAD0;
   assign s_mem_rdata = p3[2][32] ? mem_word(p3[2][31:0]) : 32'hBAD0_BAD0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic        own;
      logic [31:0] d;
   } rsp_t;
   rsp_t sb[$];
   rsp_t r;

   always @(negedge clock) begin
      if (reset) begin
         chk("one_gnt", {63'd0, inst_gnt & data_gnt}, 64'd0);
         if (inst_gnt) sb.push_back('{1'b0, mem_word(inst_addr)});
         if (data_gnt) sb.push_back('{1'b1, data_we ? 32'h0 : mem_word(data_addr)});
         if (inst_rvalid || data_rvalid) begin
            chk("rsp_pending", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
               r = sb.pop_front();
               chk("rsp_owner", {63'd0, data_rvalid}, {63'd0, r.own});
               chk("rsp_rdata", data_rvalid ? data_rdata : inst_rdata, r.d);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic load_rd(input logic [31:0] a);
      step();
      data_req = 1'b1; data_we = 1'b0; data_addr = a;
      smp(); chk("ld_gnt", data_gnt, 1);
      step();
      data_req = 1'b0; data_addr = 32'hFFFF_FFFC;
      smp();
      chk("ld_mem_en", mem_en, 1); chk("ld_mem_rw", mem_rw, 0); chk("ld_mem_addr", mem_addr, a);
      step(); step();
      smp(); chk("ld_rvalid", data_rvalid, 1); chk("ld_rdata", data_rdata, mem_word(a));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:9] exp_seq;
      int cyc, last, g;

      reset = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h100;
      data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
      s_inst_req = 1'b0; s_inst_addr = '0;
      s_data_req = 1'b0; s_data_we = 1'b0; s_data_addr = '0; s_data_wdata = '0;

      repeat (2) begin
         smp();
         chk("rst_ctl", {inst_gnt, inst_rvalid, data_gnt, data_rvalid, mem_en, mem_rw}, 0);
         chk("rst_rdata", {inst_rdata, data_rdata}, 0);
         chk("rst_mem", {mem_addr, mem_wdata}, 0);
         chk("rst_slow", {s_inst_gnt, s_data_gnt, s_mem_en, s_inst_rvalid, s_data_rvalid}, 0);
      end

      // Fetch right out of reset
      step(); reset = 1'b1;
      smp(); chk("rel_inst_gnt", inst_gnt, 1); chk("rel_data_gnt", data_gnt, 0);
      step(); inst_req = 1'b0; inst_addr = 32'h3FC;
      smp(); chk("f_mem_en", mem_en, 1); chk("f_mem_addr", mem_addr, 32'h100); chk("f_mem_rw", mem_rw, 0);
      step();
      smp(); chk("f_mem_en_low", mem_en, 0); chk("f_rvalid_early", inst_rvalid, 0);
      step();
      smp(); chk("f_rvalid", inst_rvalid, 1); chk("f_rdata", inst_rdata, 32'hDEAD_BEEF);
      chk("f_data_rvalid", data_rvalid, 0);
      step();
      smp(); chk("f_rvalid_pulse", inst_rvalid, 0); chk("f_rdata_hold", inst_rdata, 32'hDEAD_BEEF);

      // Store; inputs change after grant and must not leak into the access
      step();
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'h1234_5678;
      smp(); chk("st_gnt", data_gnt, 1); chk("st_inst_gnt", inst_gnt, 0);
      step();
      data_req = 1'b0; data_addr = 32'h44; data_wdata = 32'hFFFF_FFFF; data_we = 1'b0;
      smp();
      chk("st_mem_en", mem_en, 1); chk("st_mem_rw", mem_rw, 1);
      chk("st_mem_addr", mem_addr, 32'h40); chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      step();
      smp(); chk("st_mem_en_low", mem_en, 0); chk("st_mem_hold", mem_wdata, 32'h1234_5678);
      step();
      smp(); chk("st_rvalid", data_rvalid, 1); chk("st_rdata", data_rdata, 0);

      load_rd(32'h80);
      load_rd(32'h1234_5670);

      // Both requesters held: expect D,D,D,D,I,D,D,D,D,I spaced 4 cycles apart
      step();
      inst_req = 1'b1; inst_addr = 32'h300;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200;
      exp_seq = 10'b1111011110;
      cyc = 0; last = -1; g = 0;
      while (g < 10 && cyc < 60) begin
         smp();
         if (inst_gnt || data_gnt) begin
            chk("prio_who", data_gnt, exp_seq[g]);
            if (g > 0) chk("prio_gap", cyc - last, 4);
            last = cyc;
            g++;
         end
         step();
         cyc++;
      end
      chk("prio_count", g, 10);
      inst_req = 1'b0; data_req = 1'b0;
      step(); step(); step();

      // Abort a load in WAIT; a pending fetch wins the first cycle after release
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20;
      smp(); chk("ab_gnt", data_gnt, 1);
      step();
      data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h104;
      smp(); chk("ab_busy_no_gnt", inst_gnt, 0);
      step();
      reset = 1'b0;
      sb.delete();
      smp();
      chk("ab_ctl", {inst_gnt, inst_rvalid, data_gnt, data_rvalid, mem_en, mem_rw}, 0);
      chk("ab_mem", {mem_addr, mem_wdata}, 0);
      step();
      smp(); chk("ab_no_rvalid", data_rvalid, 0);
      step(); reset = 1'b1;
      smp(); chk("ab_regrant", inst_gnt, 1);
      // A data request raised and dropped while busy must not produce an access
      step(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h60;
      step(); data_req = 1'b0;
      step();
      smp(); chk("ab_rvalid", inst_rvalid, 1); chk("ab_rdata", inst_rdata, mem_word(32'h104));
      step();
      smp(); chk("drop_no_gnt", data_gnt, 0);
      step();
      smp(); chk("drop_no_access", mem_en, 0);

      // Latency 3 instance, load held through its response
      step();
      s_data_req = 1'b1; s_data_we = 1'b0; s_data_addr = 32'h8;
      for (int c = 0; c <= 6; c++) begin
         smp();
         chk("lat3_gnt", s_data_gnt, (c == 0 || c == 6) ? 1 : 0);
         chk("lat3_mem_en", s_mem_en, (c == 1) ? 1 : 0);
         chk("lat3_rvalid", s_data_rvalid, (c == 5) ? 1 : 0);
         if (c == 5) chk("lat3_rdata", s_data_rdata, mem_word(32'h8));
         step();
      end
      s_data_req = 1'b0;
      repeat (8) step();

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
